// File: rtl/secure_mode_fsm_pkg.sv
// Shared definitions for the secure mode controller: state encoding,
// command codes and a command legality check usable by upstream blocks.
package secure_mode_pkg;

    // Explicit 3-bit state encoding; codes 5..7 are illegal and trap to FAULT.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_RUN    = 3'd2,
        ST_LOCKED = 3'd3,
        ST_FAULT  = 3'd4
    } state_e;

    // Command codes carried in the low three bits of user_input.
    localparam logic [2:0] CMD_STOP  = 3'd0;
    localparam logic [2:0] CMD_ARM   = 3'd1;
    localparam logic [2:0] CMD_RUN   = 3'd2;
    localparam logic [2:0] CMD_LOCK  = 3'd3;
    localparam logic [2:0] CMD_CLEAR = 3'd7;

    // A command is legal when its low bits name a known command and every
    // bit from 3 up to width-1 is zero. Callers zero-extend to 32 bits.
    function automatic logic is_legal_cmd(input logic [31:0] cmd, input int width);
        logic legal;
        case (cmd[2:0])
            CMD_STOP, CMD_ARM, CMD_RUN, CMD_LOCK, CMD_CLEAR: legal = 1'b1;
            default:                                         legal = 1'b0;
        endcase
        for (int i = 3; i < 32; i++) begin
            if ((i < width) && cmd[i]) begin
                legal = 1'b0;
            end
        end
        return legal;
    endfunction

endpackage

// File: rtl/secure_mode_fsm_arm_timer.sv
// Up-counter that measures time spent in ARMED. Load clears it to zero,
// and the terminal-count flag marks the last permitted ARMED cycle.
module arm_timer #(
    parameter int ARM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CNT_W = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(ARM_TIMEOUT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Load has priority over counting so entry into ARMED always starts at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Counter register with asynchronous reset to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == TC_VAL);

endmodule

// File: rtl/secure_mode_fsm.sv
// Mode-control state machine between the user command path and the
// datapath enables. Sequences IDLE -> ARMED -> RUN, with a sticky LOCKED
// state and a FAULT state recoverable by CLEAR. All outputs are registered
// or decoded from registers only.
module secure_mode_fsm
    import secure_mode_pkg::*;
#(
    parameter int IN_W        = 3,
    parameter int ARM_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [IN_W-1:0] user_input,
    output logic [2:0]      out,
    output logic            busy,
    output logic            locked,
    output logic            fault,
    output logic            cmd_err
);

    state_e     state_q;
    state_e     state_d;
    logic       cmd_err_q;
    logic       cmd_err_d;
    logic       cmd_legal;
    logic [2:0] cmd_code;
    logic       timer_tc;

    // The timer runs only while ARMED and is held at zero everywhere else,
    // so it always starts from zero on entry to ARMED.
    arm_timer #(
        .ARM_TIMEOUT (ARM_TIMEOUT)
    ) u_arm_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (state_q != ST_ARMED),
        .en_i   (state_q == ST_ARMED),
        .tc_o   (timer_tc)
    );

    // Next-state and rejection decode; illegal state codes fall to FAULT.
    always_comb begin
        state_d   = state_q;
        cmd_err_d = 1'b0;
        cmd_legal = is_legal_cmd(32'(user_input), IN_W);
        cmd_code  = user_input[2:0];
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (!cmd_legal) begin
                        cmd_err_d = 1'b1;
                    end else if (cmd_code == CMD_ARM) begin
                        state_d = ST_ARMED;
                    end else if ((cmd_code == CMD_RUN) || (cmd_code == CMD_LOCK)) begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            ST_ARMED: begin
                if (in_valid && cmd_legal && (cmd_code == CMD_RUN)) begin
                    state_d = ST_RUN;
                end else if (in_valid && cmd_legal && (cmd_code == CMD_STOP)) begin
                    state_d = ST_IDLE;
                end else begin
                    if (timer_tc) begin
                        state_d = ST_IDLE;
                    end
                    if (in_valid && (!cmd_legal || (cmd_code == CMD_LOCK) ||
                                     (cmd_code == CMD_CLEAR))) begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (in_valid) begin
                    if (!cmd_legal) begin
                        cmd_err_d = 1'b1;
                    end else if (cmd_code == CMD_STOP) begin
                        state_d = ST_IDLE;
                    end else if (cmd_code == CMD_LOCK) begin
                        state_d = ST_LOCKED;
                    end else if (cmd_code == CMD_CLEAR) begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            ST_LOCKED: begin
                if (in_valid) begin
                    cmd_err_d = 1'b1;
                end
            end
            ST_FAULT: begin
                if (in_valid) begin
                    if (cmd_legal && (cmd_code == CMD_CLEAR)) begin
                        state_d = ST_IDLE;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase
    end

    // State and error-pulse registers; reset returns to IDLE immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cmd_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_err_q <= cmd_err_d;
        end
    end

    assign out     = state_q;
    assign busy    = (state_q == ST_ARMED) || (state_q == ST_RUN);
    assign locked  = (state_q == ST_LOCKED);
    assign fault   = (state_q == ST_FAULT);
    assign cmd_err = cmd_err_q;

endmodule

// File: tb/tb_secure_mode_fsm.sv
// Directed bench for secure_mode_fsm with hand-computed expectations.
// A second instance with a 5-bit command width covers the upper-bit check.
module tb_secure_mode_fsm;
    import secure_mode_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [2:0] user_input;
    logic [2:0] out;
    logic       busy;
    logic       locked;
    logic       fault;
    logic       cmd_err;

    logic       inValid5;
    logic [4:0] userInput5;
    logic [2:0] out5;
    logic       busy5;
    logic       locked5;
    logic       fault5;
    logic       cmdErr5;

    logic [6:0] stat;
    logic [6:0] stat5;

    int checks = 0;
    int errors = 0;

    secure_mode_fsm #(.IN_W(3), .ARM_TIMEOUT(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .user_input (user_input),
        .out        (out),
        .busy       (busy),
        .locked     (locked),
        .fault      (fault),
        .cmd_err    (cmd_err)
    );

    secure_mode_fsm #(.IN_W(5), .ARM_TIMEOUT(16)) dut5 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (inValid5),
        .user_input (userInput5),
        .out        (out5),
        .busy       (busy5),
        .locked     (locked5),
        .fault      (fault5),
        .cmd_err    (cmdErr5)
    );

    assign stat  = {out, busy, locked, fault, cmd_err};
    assign stat5 = {out5, busy5, locked5, fault5, cmdErr5};

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one cycle of inputs at the falling edge and return just after
    // the rising edge that samples them.
    task automatic applyStimulus(input logic v, input logic [2:0] cmd);
        @(negedge clk);
        in_valid   = v;
        user_input = cmd;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Compare a packed status vector {out,busy,locked,fault,cmd_err}.
    task automatic checkOutput(input string tag, input logic [6:0] obsVec,
                               input logic [2:0] expOut, input logic expBusy,
                               input logic expLocked, input logic expFault,
                               input logic expErr);
        logic [6:0] expVec;
        expVec = {expOut, expBusy, expLocked, expFault, expErr};
        checks++;
        assert (obsVec === expVec) else begin
            errors++;
            $error("[TB] FAIL %s: observed out=%0d busy=%b locked=%b fault=%b cmd_err=%b, expected out=%0d busy=%b locked=%b fault=%b cmd_err=%b",
                   tag, obsVec[6:4], obsVec[3], obsVec[2], obsVec[1], obsVec[0],
                   expOut, expBusy, expLocked, expFault, expErr);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        user_input = 3'd0;
        inValid5   = 1'b0;
        userInput5 = 5'd0;

        // Reset values
        #3;
        checkOutput("resetHold", stat, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 3'd0);
        checkOutput("afterReset", stat, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Basic sequence ARM, RUN, STOP
        applyStimulus(1'b1, 3'd1);
        checkOutput("armToArmed", stat, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd2);
        checkOutput("runToRun", stat, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd0);
        checkOutput("stopToIdle", stat, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // ARMED: ARM ignored, LOCK rejected, STOP returns to IDLE
        applyStimulus(1'b1, 3'd1);
        applyStimulus(1'b1, 3'd1);
        checkOutput("armedArmIgnored", stat, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd3);
        checkOutput("armedLockErr", stat, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 3'd0);
        checkOutput("armedStop", stat, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Timeout: ARMED for 16 cycles then IDLE
        applyStimulus(1'b1, 3'd1);
        checkOutput("toEntry", stat, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k < 16; k++) begin
            applyStimulus(1'b0, 3'd0);
            checkOutput("toHold", stat, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 3'd0);
        checkOutput("toExpire", stat, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // RUN on the terminal cycle wins over timeout
        applyStimulus(1'b1, 3'd1);
        for (int k = 1; k < 16; k++) begin
            applyStimulus(1'b0, 3'd0);
        end
        checkOutput("tcLastArmed", stat, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd2);
        checkOutput("tcRunWins", stat, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 3'd0);
        checkOutput("tcRunStays", stat, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);

        // LOCKED is sticky; every command is rejected back-to-back
        applyStimulus(1'b1, 3'd3);
        checkOutput("lockEnter", stat, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd7);
        checkOutput("lockClearErr", stat, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 3'd0);
        checkOutput("lockStopErr", stat, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 3'd1);
        checkOutput("lockArmErr", stat, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 3'd0);
        checkOutput("lockErrClears", stat, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset between clock edges
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncReset", stat, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // IDLE rejections and silent ignores
        applyStimulus(1'b1, 3'd5);
        checkOutput("idleIllegal", stat, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 3'd2);
        checkOutput("idleRunErr", stat, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 3'd7);
        checkOutput("idleClearQuiet", stat, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Wide command: nonzero upper bits make ARM illegal
        @(negedge clk);
        inValid5   = 1'b1;
        userInput5 = 5'b01001;
        @(posedge clk);
        #1;
        inValid5 = 1'b0;
        checkOutput("wideUpperBits", stat5, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        inValid5   = 1'b1;
        userInput5 = 5'b00001;
        @(posedge clk);
        #1;
        inValid5 = 1'b0;
        checkOutput("wideLegalArm", stat5, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Illegal state code traps to FAULT
        @(negedge clk);
        force dut.state_q = state_e'(3'd6);
        #1;
        release dut.state_q;
        #1;
        checkOutput("illegalCode", stat, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("trapToFault", stat, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 3'd0);
        checkOutput("faultStopErr", stat, 3'd4, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 3'd7);
        checkOutput("faultClear", stat, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // in_valid low holds state in IDLE
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b0, 3'($urandom));
            checkOutput("holdIdle", stat, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // in_valid low holds state in RUN
        applyStimulus(1'b1, 3'd1);
        applyStimulus(1'b1, 3'd2);
        checkOutput("reachRun", stat, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b0, 3'($urandom));
            checkOutput("holdRun", stat, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        end

        // RUN rejects CLEAR, then STOP returns to IDLE
        applyStimulus(1'b1, 3'd7);
        checkOutput("runClearErr", stat, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 3'd0);
        checkOutput("runStop", stat, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/secure_mode_fsm.md
# secure_mode_fsm

Parametrised mode-control state machine that accepts validated commands, sequences IDLE → ARMED → RUN, and provides a sticky LOCKED state and a recoverable FAULT state. The encoding is explicit. Every unused state code is trapped to FAULT, so there are no undefined or unreachable transitions. It sits between the user command path and the datapath enables, which it drives through decoded status outputs.

## Interface
- IN_W, 3: command width, minimum 3.
- ARM_TIMEOUT, 16: cycles allowed in ARMED without a RUN command, minimum 2.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  qualifies user_input for one cycle.
- user_input  input  IN_W  command code.
- out  output  3  current state encoding.
- busy  output  1  high in ARMED or RUN.
- locked  output  1  high in LOCKED.
- fault  output  1  high in FAULT.
- cmd_err  output  1  one-cycle registered pulse for a rejected command.

## Operation
- State codes: IDLE=0, ARMED=1, RUN=2, LOCKED=3, FAULT=4. Codes 5–7 are illegal.
- Command codes:
  - STOP=0, ARM=1, RUN=2, LOCK=3, CLEAR=7.
  - Codes 4–6 are illegal.
  - When IN_W>3, any nonzero bit above bit 2 makes the command illegal.
- A command is acted on only on an edge where in_valid=1. With in_valid=0 the state holds, except for the ARMED timeout.
- Transitions:
  - IDLE: ARM → ARMED. STOP and CLEAR are ignored silently. RUN, LOCK and illegal codes stay in IDLE and assert cmd_err.
  - ARMED: RUN → RUN. STOP → IDLE. Timeout → IDLE. ARM is ignored. LOCK, CLEAR and illegal codes assert cmd_err.
  - RUN: STOP → IDLE. LOCK → LOCKED. RUN and ARM are ignored. CLEAR and illegal codes assert cmd_err.
  - LOCKED: exits only via rst_n. Every valid command, including CLEAR, asserts cmd_err.
  - FAULT: CLEAR → IDLE. Every other valid command asserts cmd_err.
  - Any illegal state code (5–7) → FAULT on the next edge, regardless of input.
- ARMED timer:
  - Width is $clog2(ARM_TIMEOUT). Cleared to 0 on entry to ARMED.
  - Increments each cycle spent in ARMED.
  - On the edge where the count equals ARM_TIMEOUT-1 and no RUN or STOP is accepted, the next state is IDLE.
  - RUN accepted on that same edge takes priority: next state is RUN.
- Output decode comes from the state register only: out = state code; busy, locked and fault as listed in Interface.

## Timing
- Reset values: state IDLE, out=0, busy=0, locked=0, fault=0, cmd_err=0, timer=0.
- Reset mid-operation clears LOCKED and FAULT immediately, without waiting for a clock edge.
- Latency: a command sampled at edge N shows its new state on out after edge N, i.e. one cycle.
- cmd_err is high for exactly the cycle following the rejecting edge. Back-to-back rejected commands keep it high continuously.
- Timeout: ARMED is entered at edge E. With no commands, out returns to 0 after edge E+ARM_TIMEOUT.
- No input is ever combinationally routed to an output.

## Structure
- Package secure_mode_pkg:
  - State enum (3-bit) and command code localparams (STOP, ARM, RUN, LOCK, CLEAR).
  - Function is_legal_cmd(IN_W) usable by upstream blocks.
- One sub-module, arm_timer:
  - Loadable up-counter with a terminal-count flag, parametrised by ARM_TIMEOUT.
  - Instantiated once.
- Next-state logic is a single combinational process with a full case and a default branch to FAULT. The state register is separate.

## Test plan
- Reset, then ARM, RUN, STOP with in_valid pulses → out=1, 2, 0. busy high only while out is 1 or 2. cmd_err stays 0.
- ARM, then idle with ARM_TIMEOUT=16 → out=1 for 16 cycles, then 0. Repeat with RUN issued on the 16th cycle → out=2, no return to IDLE.
- From RUN: LOCK, then CLEAR, STOP, ARM → out=3 and locked=1 throughout; cmd_err pulses once per command. Assert rst_n low mid-cycle → out=0 and locked=0 asynchronously.
- In IDLE, user_input=5, then 3'b010 (RUN) → cmd_err pulses, out stays 0. With IN_W=5, user_input=5'b01001 → illegal, cmd_err pulses.
- Force the state register to 6 → after the next edge out=4, fault=1. CLEAR → out=0. STOP while in FAULT → cmd_err pulses, out stays 4.
- in_valid=0 with random user_input for 100 cycles in IDLE and in RUN → state never changes and cmd_err stays 0.
